// File: rtl/step_counter_if.sv
// Bundles the control, data and status signals of step_counter.
// The master drives the controls and observes the status; the counter is the slave.
interface step_counter_if #(
    parameter int DATAWIDTH = 8
);
    logic                 en;
    logic                 dir;
    logic [DATAWIDTH-1:0] step;
    logic                 sat;
    logic                 load;
    logic [DATAWIDTH-1:0] load_val;
    logic                 ovf_clr;
    logic [DATAWIDTH-1:0] count;
    logic                 tc;
    logic                 ovf;

    modport master (
        output en, dir, step, sat, load, load_val, ovf_clr,
        input  count, tc, ovf
    );

    modport slave (
        input  en, dir, step, sat, load, load_val, ovf_clr,
        output count, tc, ovf
    );
endinterface

// File: rtl/step_counter.sv
// Up/down counter with a programmable step and a programmable upper bound
// MAXVAL. At a bound it either saturates or wraps modulo MAXVAL+1.
// It raises a registered terminal-count pulse and a sticky overflow flag.
module step_counter #(
    parameter int          DATAWIDTH = 8,
    parameter int unsigned MAXVAL    = 2**DATAWIDTH-1
) (
    input  logic          Clk,
    input  logic          Rst,
    step_counter_if.slave bus
);
    // One extra bit of headroom, so that count+step and count+MAXVAL+1 never truncate.
    localparam logic [DATAWIDTH:0] MAX_X = (DATAWIDTH+1)'(MAXVAL);
    localparam logic [DATAWIDTH:0] MOD_X = (DATAWIDTH+1)'(MAXVAL + 1);

    logic [DATAWIDTH-1:0] count_q, count_d;
    logic                 tc_q, tc_d;
    logic                 ovf_q, ovf_d;

    logic [DATAWIDTH:0]   step_x;
    logic [DATAWIDTH:0]   ld_x;
    logic [DATAWIDTH:0]   cnt_x;
    logic [DATAWIDTH:0]   sum_x;
    logic [DATAWIDTH:0]   nxt_x;
    logic                 ovf_set;

    // Next-state logic. Priority is load over en; otherwise the count holds.
    always_comb begin
        // Clamp out-of-range step and load values to MAXVAL.
        step_x = {1'b0, bus.step};
        if (step_x > MAX_X) begin
            step_x = MAX_X;
        end
        ld_x = {1'b0, bus.load_val};
        if (ld_x > MAX_X) begin
            ld_x = MAX_X;
        end
        cnt_x   = {1'b0, count_q};
        sum_x   = cnt_x + step_x;
        nxt_x   = cnt_x;
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_set = 1'b0;

        if (bus.load) begin
            count_d = DATAWIDTH'(ld_x);
        end else if (bus.en && (step_x != '0)) begin
            // A zero step is a no-op, so it never reaches this branch.
            if (bus.dir) begin
                if (sum_x > MAX_X) begin
                    // Crossing the top bound. Starting at MAXVAL with sat=1 lands here too.
                    ovf_set = 1'b1;
                    tc_d    = 1'b1;
                    nxt_x   = bus.sat ? MAX_X : (sum_x - MOD_X);
                end else begin
                    tc_d    = (sum_x == MAX_X);
                    nxt_x   = sum_x;
                end
            end else begin
                if (step_x > cnt_x) begin
                    // Crossing zero. Starting at 0 with sat=1 lands here too.
                    ovf_set = 1'b1;
                    tc_d    = 1'b1;
                    nxt_x   = bus.sat ? '0 : (cnt_x + MOD_X - step_x);
                end else begin
                    nxt_x   = cnt_x - step_x;
                    tc_d    = (step_x == cnt_x);
                end
            end
            count_d = DATAWIDTH'(nxt_x);
        end

        // A set wins over a clear in the same cycle.
        ovf_d = ovf_set | (ovf_q & ~bus.ovf_clr);
    end

    // State registers; reset clears everything immediately, without a clock edge.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.ovf   = ovf_q;
endmodule

// File: doc/step_counter.md
STEP_COUNTER -- requirements
Module: step_counter

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 8: width of the count, step and load value.
REQ-002 The block SHALL have parameter MAXVAL, default 2**DATAWIDTH-1: the highest legal count; legal range is 1..2**DATAWIDTH-1.
REQ-003 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port en, input, 1 bit: advance the count by step this cycle.
REQ-006 The block SHALL have port dir, input, 1 bit: 1 = count up, 0 = count down.
REQ-007 The block SHALL have port step, input, DATAWIDTH bits: the increment or decrement amount.
REQ-008 The block SHALL have port sat, input, 1 bit: 1 = saturate at the bounds, 0 = wrap modulo MAXVAL+1.
REQ-009 The block SHALL have port load, input, 1 bit: synchronous load of load_val.
REQ-010 The block SHALL have port load_val, input, DATAWIDTH bits: the value to load.
REQ-011 The block SHALL have port ovf_clr, input, 1 bit: clears the ovf flag.
REQ-012 The block SHALL have port count, output, DATAWIDTH bits: the registered count.
REQ-013 The block SHALL have port tc, output, 1 bit: registered single-cycle terminal-count pulse.
REQ-014 The block SHALL have port ovf, output, 1 bit: sticky flag recording a wrap or saturation event.

Function
REQ-015 Priority SHALL be Rst, then load, then en; with none of them active, count SHALL hold.
REQ-016 When load=1, the next count SHALL be min(load_val, MAXVAL); tc and ovf SHALL NOT be affected by a load.
REQ-017 Arithmetic SHALL be computed in DATAWIDTH+1 bits so that no intermediate result is truncated.
REQ-018 Up, no boundary crossing: if count+step <= MAXVAL, next count SHALL be count+step.
REQ-019 Up, boundary crossing: if count+step > MAXVAL, next count SHALL be MAXVAL when sat=1, or count+step-(MAXVAL+1) when sat=0.
REQ-020 Down, no boundary crossing: if step <= count, next count SHALL be count-step.
REQ-021 Down, boundary crossing: if step > count, next count SHALL be 0 when sat=1, or count+(MAXVAL+1)-step when sat=0.
REQ-022 An en cycle with step=0 SHALL hold count and SHALL NOT assert tc or set ovf.
REQ-023 A step value greater than MAXVAL SHALL be treated as MAXVAL.
REQ-024 tc SHALL be 1 in the cycle after an en cycle that meets either condition below, and 0 otherwise:
- the up result equals MAXVAL or crosses it;
- the down result equals 0 or crosses it.
REQ-025 An en cycle that starts at MAXVAL (counting up) or at 0 (counting down) with sat=1 SHALL assert tc again and set ovf.
REQ-026 ovf SHALL be set by any en cycle that takes a boundary-crossing branch (REQ-019 or REQ-021), or meets the REQ-025 condition.
REQ-027 ovf SHALL clear on ovf_clr=1; when set and clear occur in the same cycle, set SHALL win.
REQ-028 dir, sat and step SHALL be sampled only in en cycles, and changing them between cycles SHALL take effect immediately, with no state kept.
REQ-029 Latency SHALL be one cycle from an en or load edge to the updated count, tc and ovf.

Reset
REQ-030 On Rst=1, count, tc and ovf SHALL go to 0 immediately, without waiting for a clock edge.
REQ-031 Rst SHALL override load and en, including when asserted mid-operation.
REQ-032 After Rst deasserts, the first en or load SHALL take effect on the next rising edge of Clk.

Verification
REQ-033 With DATAWIDTH=4, MAXVAL=9, sat=0, dir=1, step=3 and en held, count SHALL run 0,3,6,9,2,5; tc SHALL pulse after 9 and after 2; ovf SHALL set after the 9-to-2 wrap.
REQ-034 With the same configuration, sat=1, starting from 8 with step=3, count SHALL go 8,9,9; tc SHALL be 1 on both 9s; ovf SHALL be 1.
REQ-035 With dir=0, sat=0, step=4, starting from 2, count SHALL go to 8 (2+10-4); tc SHALL be 1; ovf SHALL be 1.
REQ-036 load=1 with load_val=15 and MAXVAL=9, with en=1 in the same cycle, SHALL give count=9, tc=0 and ovf unchanged.
REQ-037 ovf_clr=1 together with a wrap event SHALL leave ovf=1; ovf_clr alone on the next cycle SHALL give ovf=0.
REQ-038 Rst pulsed between clock edges while count=7 SHALL make count, tc and ovf read 0 before the next edge, and en=1 with step=1 afterwards SHALL give count=1.
